// File: rtl/line_buffer_pkg.sv
// Shared types, default sizes and width helpers for the line buffer family.
package line_buffer_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_LINE_LEN  = 32;
    localparam int DEF_NUM_LINES = 3;

    // Counter widths for the default geometry
    localparam int COL_W = $clog2(DEF_LINE_LEN);
    localparam int ROW_W = $clog2(DEF_NUM_LINES);

    // Pixel type at the default width
    typedef logic [DEF_WIDTH-1:0] pixel_t;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_delay_ram.sv
// One circular line delay: LINE_LEN x WIDTH storage, read-before-write.
// rdata shows the entry at addr before this cycle's write, so cascading
// instances shift a column down one line per accepted pixel.
module line_delay_ram
    import line_buffer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_LINE_LEN,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Overwrite the slot once its old value has been passed on via rdata
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/multi_line_buffer.sv
// Multi-line buffer: stores NUM_LINES-1 image lines and presents, for every
// accepted pixel, the vertical column of NUM_LINES pixels ending at it.
// Slice 0 of out_col is the newest pixel, slice k is from k lines earlier.
module multi_line_buffer
    import line_buffer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LINE_LEN  = DEF_LINE_LEN,
    parameter int NUM_LINES = DEF_NUM_LINES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    output logic [NUM_LINES*WIDTH-1:0]   out_col,
    output logic [$clog2(LINE_LEN)-1:0]  out_col_idx,
    output logic                         primed
);

    localparam int CW = $clog2(LINE_LEN);
    localparam int RW = cnt_w(NUM_LINES);
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);
    localparam logic [RW-1:0] FULL_ROW = RW'(NUM_LINES - 1);

    logic [CW-1:0]                    col_cnt;
    logic [RW-1:0]                    row_cnt;
    logic                             accept;
    logic [(NUM_LINES-1)*WIDTH-1:0]   rd_bus;
    logic [NUM_LINES*WIDTH-1:0]       col_all;

    // frame_start wins: a pixel offered in the restart cycle is dropped
    assign accept  = in_valid && !frame_start;
    assign primed  = (row_cnt == FULL_ROW);
    // Column as it stands this cycle: new pixel at the bottom, delays above
    assign col_all = {rd_bus, in_data};

    // Delay k is fed by the read port of delay k-1 (delay 0 by in_data)
    for (genvar k = 0; k < NUM_LINES - 1; k++) begin : g_delay
        line_delay_ram #(
            .WIDTH (WIDTH),
            .DEPTH (LINE_LEN),
            .AW    (CW)
        ) u_ram (
            .clk   (clk),
            .en    (accept),
            .addr  (col_cnt),
            .wdata (col_all[k*WIDTH +: WIDTH]),
            .rdata (rd_bus[k*WIDTH +: WIDTH])
        );
    end

    // Column pointer wraps per line; row count saturates once primed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (frame_start) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (in_valid) begin
            if (col_cnt == LAST_COL) begin
                col_cnt <= '0;
                if (row_cnt != FULL_ROW) begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Register the column; valid only when primed before this pixel arrived
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_col     <= '0;
            out_col_idx <= '0;
        end else if (frame_start) begin
            out_valid   <= 1'b0;
        end else if (in_valid) begin
            out_valid   <= primed;
            out_col     <= col_all;
            out_col_idx <= col_cnt;
        end else begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Bench for multi_line_buffer with WIDTH=16, LINE_LEN=8, NUM_LINES=3.
module tb_multi_line_buffer;

    localparam int W  = 16;
    localparam int L  = 8;
    localparam int K  = 3;
    localparam int NV = 6;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [K*W-1:0] out_col;
    logic [2:0]    out_col_idx;
    logic          primed;

    multi_line_buffer #(.WIDTH(W), .LINE_LEN(L), .NUM_LINES(K)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_col     (out_col),
        .out_col_idx (out_col_idx),
        .primed      (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             pix;
        logic [K*W-1:0] col;
        logic [2:0]     idx;
    } vec_t;

    typedef struct {
        logic           v;
        logic           pr;
        logic [2:0]     idx;
        logic [K*W-1:0] col;
        logic           col_known;
    } exp_t;

    vec_t   vecs [NV];
    exp_t   sbq [$];
    logic [W-1:0] hist [0:1023];
    int     p;
    logic [K*W-1:0] m_col;
    logic [2:0] m_idx;
    logic   m_known;
    bit     use_tbl;
    int     total;
    int     bad;

    task automatic chk(input string nm, input logic [K*W-1:0] act, input logic [K*W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] pat(input int n);
        return W'((n / L) * 256 + (n % L));
    endfunction

    task automatic model_reset();
        p       = 0;
        m_col   = '0;
        m_idx   = '0;
        m_known = 1'b1;
    endtask

    task automatic check_out();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=0 required=1");
            return;
        end
        e = sbq.pop_front();
        chk("out_valid", {47'd0, out_valid}, {47'd0, e.v});
        chk("primed", {47'd0, primed}, {47'd0, e.pr});
        chk("out_col_idx", {45'd0, out_col_idx}, {45'd0, e.idx});
        if (e.col_known) chk("out_col", out_col, e.col);
    endtask

    // Drive one cycle, push the model's expectation, check after the edge
    task automatic drive(input logic v, input logic fs, input logic [W-1:0] d);
        exp_t e;
        int   ti;
        ti          = -1;
        in_valid    = v;
        frame_start = fs;
        in_data     = d;
        e.v         = 1'b0;
        if (fs) begin
            p = 0;
        end else if (v) begin
            if (use_tbl)
                for (int i = 0; i < NV; i++)
                    if (vecs[i].pix == p) ti = i;
            hist[p] = d;
            m_idx   = 3'(p % L);
            if (p >= (K - 1) * L) begin
                m_col   = {hist[p - 2*L], hist[p - L], hist[p]};
                m_known = 1'b1;
                e.v     = 1'b1;
            end else begin
                m_known = 1'b0;
            end
            p++;
        end
        e.pr        = (p >= (K - 1) * L);
        e.idx       = m_idx;
        e.col       = m_col;
        e.col_known = m_known;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out();
        if (ti >= 0) begin
            chk($sformatf("tbl_col_p%0d", vecs[ti].pix), out_col, vecs[ti].col);
            chk($sformatf("tbl_idx_p%0d", vecs[ti].pix), {45'd0, out_col_idx}, {45'd0, vecs[ti].idx});
        end
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic stream(input int from, input int upto);
        for (int n = from; n < upto; n++) drive(1'b1, 1'b0, pat(n));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{16, 48'h0000_0100_0200, 3'd0};
        vecs[1] = '{17, 48'h0001_0101_0201, 3'd1};
        vecs[2] = '{20, 48'h0004_0104_0204, 3'd4};
        vecs[3] = '{23, 48'h0007_0107_0207, 3'd7};
        vecs[4] = '{31, 48'h0107_0207_0307, 3'd7};
        vecs[5] = '{32, 48'h0200_0300_0400, 3'd0};

        rst         = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {47'd0, out_valid}, 48'd0);
        chk("rst_out_col", out_col, 48'd0);
        chk("rst_out_col_idx", {45'd0, out_col_idx}, 48'd0);
        chk("rst_primed", {47'd0, primed}, 48'd0);
        rst = 1'b1;
        model_reset();
        use_tbl = 1'b1;

        // Priming, line wrap and a five-cycle stall at column 4 of row 2
        stream(0, 20);
        repeat (5) drive(1'b0, 1'b0, 16'hBEEF);
        stream(20, 40);

        // Restart with a concurrent pixel that must be discarded
        drive(1'b1, 1'b1, 16'hDEAD);
        stream(0, 20);

        // Async reset pulse between edges, during row 2
        #1;
        rst = 1'b0;
        #3;
        chk("arst_out_valid", {47'd0, out_valid}, 48'd0);
        chk("arst_out_col", out_col, 48'd0);
        chk("arst_out_col_idx", {45'd0, out_col_idx}, 48'd0);
        chk("arst_primed", {47'd0, primed}, 48'd0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        stream(0, 24);

        // Random frames with random gaps and data
        use_tbl = 1'b0;
        for (int f = 0; f < 4; f++) begin
            int n_px;
            int acc;
            n_px = $urandom_range(16, 40);
            acc  = 0;
            drive(1'($urandom_range(0, 1)), 1'b1, W'($urandom));
            for (int c = 0; c < 400 && acc < n_px; c++) begin
                logic v;
                v = ($urandom_range(0, 9) < 7);
                drive(v, 1'b0, W'($urandom));
                if (v) acc++;
            end
            if (acc < n_px) begin
                total++;
                bad++;
                $display("FAIL rand_budget actual=%0d required=%0d", acc, n_px);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_line_buffer.md
Name: multi_line_buffer

Overview:
- Parametrised successor to the single-bit line buffer. Stores NUM_LINES-1 full image lines of WIDTH-bit pixels.
- For every accepted input pixel, presents a vertical column of NUM_LINES pixels: the current pixel plus the same column from each earlier line.
- Feeds the sliding-window (KxK) stage of the convolution datapath.
- Adds stall tolerance (in_valid gating), frame restart and priming status.

Parameters:
- WIDTH, 16, pixel width in bits.
- LINE_LEN, 32, pixels per image line; must be >= 2.
- NUM_LINES, 3, column height (kernel height K); must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  synchronous clear of counters/priming; takes priority over in_valid in the same cycle.
- in_valid  in  1  pixel on in_data is accepted this cycle.
- in_data  in  WIDTH  input pixel, raster order.
- out_valid  out  1  out_col holds a fully primed column.
- out_col  out  NUM_LINES*WIDTH  slice k = pixel from k lines ago at the same column; slice 0 = newest.
- out_col_idx  out  $clog2(LINE_LEN)  column index of the pixel in slice 0.
- primed  out  1  NUM_LINES-1 complete lines have been stored since reset/frame_start.

Behaviour:
- One clock; reset is asynchronous and active-low (port rst), clock port clk.
- Reset (rst=0), all immediate:
  - out_valid=0, out_col=0, out_col_idx=0, primed=0.
  - Column counter=0, row counter=0.
  - RAM contents are not cleared (don't-care); the priming logic masks them.
- Storage: NUM_LINES-1 circular line delays, each LINE_LEN deep, sharing one write/read pointer equal to the column counter.
  - Accepted pixel: delay 0 reads the old entry, then writes in_data.
  - Delay k writes the value read from delay k-1 (cascade).
- Latency: 1 cycle. The pixel accepted at edge n appears in out_col slice 0 after edge n; outputs are registered.
- in_valid=0:
  - No counter, RAM or output change.
  - out_valid drops to 0 the next cycle; out_col holds its last value.
- Column counter: increments per accepted pixel, wraps LINE_LEN-1 -> 0. On wrap the row counter increments, saturating at NUM_LINES-1.
- primed = (row counter == NUM_LINES-1).
- out_valid is registered, set when a pixel is accepted while primed is already 1 (pre-edge value). The first valid column is therefore pixel index (NUM_LINES-1)*LINE_LEN of the frame.
- frame_start=1:
  - Next edge: column and row counters -> 0, primed -> 0, out_valid -> 0.
  - Any in_valid pixel in that same cycle is discarded.
  - RAM is not cleared.
- Reset asserted mid-line: all state drops immediately. After release, the stream is treated as a new frame.
- out_col_idx: registered copy of the column counter value used for the accepted pixel.
- Arithmetic: counters are unsigned $clog2 widths. No pixel arithmetic; data passes unmodified.

Decomposition:
- Package line_buffer_pkg:
  - pixel_t (logic [WIDTH-1:0]) via a parametrised typedef helper.
  - Constants COL_W=$clog2(LINE_LEN) and ROW_W=$clog2(NUM_LINES).
- Sub-module line_delay_ram:
  - Single circular buffer, LINE_LEN x WIDTH.
  - Inputs: en, addr, wdata. Output: rdata, read-before-write.
  - Instantiated NUM_LINES-1 times in a generate loop.
- Top holds the counters, priming logic and output registers.

Test Plan:
All scenarios use WIDTH=16, LINE_LEN=8, NUM_LINES=3, with the stream pixel value = 0x100*row + col.
1. Priming: stream 16 pixels (rows 0-1) continuously -> out_valid stays 0 and primed rises after pixel 15. Pixel 16 (0x0200) -> next cycle out_valid=1, out_col = {0x0000, 0x0100, 0x0200} (slice2..0), out_col_idx=0.
2. Wrap: continue through row 3 -> at col 7 of row 3, out_col = {0x0107, 0x0207, 0x0307}. Next pixel has out_col_idx=0 and slices {0x0200, 0x0300, 0x0400}.
3. Stall: after priming, drop in_valid for 5 cycles mid-line (col 4) -> out_valid=0, counters frozen. On resume, out_col_idx=4 and the column values are unchanged from the no-stall case.
4. frame_start with concurrent in_valid -> that pixel is dropped, primed=0, and the next 16 pixels give out_valid=0. Pixel 16 of the new frame reproduces scenario 1 values.
5. Async reset pulse (rst=0 for 3 ns, between edges) during row 2 -> outputs and primed clear without a clock edge. Behaviour after release matches scenario 1.
6. Randomised 4-frame stream with random in_valid gaps -> each out_col matches a scoreboard model.
